elm_inference_sequencer: RTL and testbench

Top-level scheduler for one ELM inference. On a start request it launches the hidden-layer stage (M1), the output-layer stage (M2) and the argmax/digit stage (M3) in order, one start pulse and one done handshake per stage. It guards each stage with a watchdog and captures the 10-bit one-hot digit at the end. It also owns the output register-file read port, sharing it between the M3 scan and a debug reader.

---
 rtl/elm_pkg.sv | 40 ++++
 rtl/elm_wd_timer.sv | 37 +++
 rtl/elm_inference_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_elm_inference_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// ============================================================================
// Module      : elm_pkg
// Description : Shared types and constants for the ELM inference sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elm_pkg;

    localparam int DIGIT_W = 10;
    localparam int RADDR_W = 4;

    localparam logic [1:0] STG_NONE = 2'd0;
    localparam logic [1:0] STG_M1   = 2'd1;
    localparam logic [1:0] STG_M2   = 2'd2;
    localparam logic [1:0] STG_M3   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_M1 = 3'd1,
        ST_RUN_M2 = 3'd2,
        ST_RUN_M3 = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Stage code reported in err_stage for a given sequencer state.
    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] stg;
        case (s)
            ST_RUN_M1: stg = STG_M1;
            ST_RUN_M2: stg = STG_M2;
            ST_RUN_M3: stg = STG_M3;
            default:   stg = STG_NONE;
        endcase
        return stg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/elm_wd_timer.sv
// ============================================================================
// Module      : elm_wd_timer
// Description : Per-stage watchdog counter; flags when the count hits TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elm_wd_timer #(
    parameter int TIMEOUT = 1023,
    parameter int WD_W    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WD_W-1:0] C_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/elm_inference_sequencer.sv
// ============================================================================
// Module      : elm_inference_sequencer
// Description : Runs M1 -> M2 -> M3 for one inference with per-stage watchdog,
//               captures the one-hot digit and arbitrates the regfile read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elm_inference_sequencer
    import elm_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int WD_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] result,
    output logic               result_valid,
    output logic               error,
    output logic [1:0]         err_stage,
    output logic               m1_start,
    output logic               m2_start,
    output logic               m3_start,
    input  logic               m1_done,
    input  logic               m2_done,
    input  logic               m3_done,
    input  logic [DIGIT_W-1:0] m3_digit,
    input  logic [RADDR_W-1:0] m3_raddr,
    input  logic               dbg_req,
    input  logic [RADDR_W-1:0] dbg_raddr,
    output logic               dbg_gnt,
    output logic [RADDR_W-1:0] regf_raddr
);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [DIGIT_W-1:0] r_result;
    logic               r_result_valid;
    logic               r_error;
    logic [1:0]         r_err_stage;
    logic               r_m1_start;
    logic               r_m2_start;
    logic               r_m3_start;

    logic w_in_run;
    logic w_first;
    logic w_cur_done;
    logic w_stage_done;
    logic w_wd_expired;
    logic w_timeout;
    logic w_abort;
    logic w_wd_clr;

    assign w_in_run = (r_state == ST_RUN_M1) || (r_state == ST_RUN_M2) ||
                      (r_state == ST_RUN_M3);

    // The launch pulse is high exactly in the first cycle of a RUN state.
    assign w_first = r_m1_start | r_m2_start | r_m3_start;

    always_comb begin
        w_cur_done = 1'b0;
        case (r_state)
            ST_RUN_M1: w_cur_done = m1_done;
            ST_RUN_M2: w_cur_done = m2_done;
            ST_RUN_M3: w_cur_done = m3_done;
            default:   w_cur_done = 1'b0;
        endcase
    end

    assign w_stage_done = w_in_run & ~w_first & w_cur_done;
    assign w_abort      = w_in_run & abort;
    assign w_timeout    = w_in_run & w_wd_expired & ~w_stage_done;

    // Hold the counter at zero outside RUN and on every state exit so each
    // stage starts counting from zero in its launch cycle.
    assign w_wd_clr = ~w_in_run | w_stage_done | w_timeout | w_abort;

    elm_wd_timer #(
        .TIMEOUT (TIMEOUT),
        .WD_W    (WD_W)
    ) u_wd_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clr),
        .i_enable  (w_in_run),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_err_stage    <= STG_NONE;
            r_m1_start     <= 1'b0;
            r_m2_start     <= 1'b0;
            r_m3_start     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_m1_start <= 1'b0;
            r_m2_start <= 1'b0;
            r_m3_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state        <= ST_RUN_M1;
                        r_busy         <= 1'b1;
                        r_m1_start     <= 1'b1;
                        r_error        <= 1'b0;
                        r_err_stage    <= STG_NONE;
                        r_result_valid <= 1'b0;
                        r_result       <= '0;
                    end
                end
                ST_RUN_M1, ST_RUN_M2, ST_RUN_M3: begin
                    // Priority: abort, then stage done, then watchdog.
                    if (w_abort) begin
                        r_state        <= ST_IDLE;
                        r_busy         <= 1'b0;
                        r_result_valid <= 1'b0;
                    end else if (w_stage_done) begin
                        case (r_state)
                            ST_RUN_M1: begin
                                r_state    <= ST_RUN_M2;
                                r_m2_start <= 1'b1;
                            end
                            ST_RUN_M2: begin
                                r_state    <= ST_RUN_M3;
                                r_m3_start <= 1'b1;
                            end
                            default: begin
                                r_state        <= ST_DONE;
                                r_busy         <= 1'b0;
                                r_done         <= 1'b1;
                                r_result       <= m3_digit;
                                r_result_valid <= 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_state        <= ST_IDLE;
                        r_busy         <= 1'b0;
                        r_error        <= 1'b1;
                        r_err_stage    <= stage_of(r_state);
                        r_result_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign err_stage    = r_err_stage;
    assign m1_start     = r_m1_start;
    assign m2_start     = r_m2_start;
    assign m3_start     = r_m3_start;

    // Grant is forced low while reset is asserted so the port follows M3.
    assign dbg_gnt    = rst & dbg_req & (r_state != ST_RUN_M3);
    assign regf_raddr = dbg_gnt ? dbg_raddr : m3_raddr;

endmodule

`default_nettype wire

// File: tb/tb_elm_inference_sequencer.sv
// ============================================================================
// Module      : tb_elm_inference_sequencer
// Description : Directed scoreboard bench for elm_inference_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elm_inference_sequencer;

    localparam int C_TO = 8;

    localparam int EV_M1   = 1;
    localparam int EV_M2   = 2;
    localparam int EV_M3   = 3;
    localparam int EV_DONE = 4;
    localparam int EV_ERR  = 5;

    typedef struct {
        int         kind;
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [9:0] result;
    logic       result_valid;
    logic       error;
    logic [1:0] err_stage;
    logic       m1_start;
    logic       m2_start;
    logic       m3_start;
    logic       m1_done;
    logic       m2_done;
    logic       m3_done;
    logic [9:0] m3_digit;
    logic [3:0] m3_raddr;
    logic       dbg_req;
    logic [3:0] dbg_raddr;
    logic       dbg_gnt;
    logic [3:0] regf_raddr;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    logic prev_err = 1'b0;
    ev_t exp_q[$];

    elm_inference_sequencer #(
        .TIMEOUT (C_TO),
        .WD_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .err_stage    (err_stage),
        .m1_start     (m1_start),
        .m2_start     (m2_start),
        .m3_start     (m3_start),
        .m1_done      (m1_done),
        .m2_done      (m2_done),
        .m3_done      (m3_done),
        .m3_digit     (m3_digit),
        .m3_raddr     (m3_raddr),
        .dbg_req      (dbg_req),
        .dbg_raddr    (dbg_raddr),
        .dbg_gnt      (dbg_gnt),
        .regf_raddr   (regf_raddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [9:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int kind, input logic [9:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%h, expected none", kind, cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%h, expected kind=%0d cyc=%0d val=%h",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: every launch pulse, done pulse and error rise consumes one
    // scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            if (m1_start) mon(EV_M1, 10'd0);
            if (m2_start) mon(EV_M2, 10'd0);
            if (m3_start) mon(EV_M3, 10'd0);
            if (done) begin
                mon(EV_DONE, result);
                chk("done_result_valid", {31'd0, result_valid}, 32'd1);
                chk("done_busy", {31'd0, busy}, 32'd0);
            end
            if (error && !prev_err) mon(EV_ERR, {8'd0, err_stage});
        end
        prev_err = error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_nominal(input logic [9:0] digit);
        int c0;
        c0 = cyc;
        push(EV_M1, c0 + 1, 10'd0);
        push(EV_M2, c0 + 3, 10'd0);
        push(EV_M3, c0 + 5, 10'd0);
        push(EV_DONE, c0 + 7, digit);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_error", {31'd0, error}, 32'd0);
        chk("start_clears_stage", {30'd0, err_stage}, 32'd0);
        chk("start_clears_valid", {31'd0, result_valid}, 32'd0);
        chk("start_clears_result", {22'd0, result}, 32'd0);
        chk("busy_in_m1", {31'd0, busy}, 32'd1);
        step();
        m1_done = 1'b1;
        step();
        m1_done = 1'b0;
        step();
        m2_done = 1'b1;
        step();
        m2_done = 1'b0;
        step();
        m3_done  = 1'b1;
        m3_digit = digit;
        step();
        m3_done  = 1'b0;
        m3_digit = 10'd0;
        step();
        chk("valid_held", {31'd0, result_valid}, 32'd1);
        chk("result_held", {22'd0, result}, {22'd0, digit});
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_timeout(input int stage);
        int c0;
        c0 = cyc;
        push(EV_M1, c0 + 1, 10'd0);
        push(EV_M2, c0 + 3, 10'd0);
        if (stage == 2) begin
            push(EV_ERR, c0 + 3 + C_TO + 1, 10'd2);
        end else begin
            push(EV_M3, c0 + 5, 10'd0);
            push(EV_ERR, c0 + 5 + C_TO + 1, 10'd3);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        m1_done = 1'b1;
        step();
        m1_done = 1'b0;
        if (stage == 3) begin
            step();
            m2_done = 1'b1;
            step();
            m2_done = 1'b0;
        end
        repeat (C_TO + 2) step();
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_error", {31'd0, error}, 32'd1);
        chk("timeout_stage", {30'd0, err_stage}, stage);
        chk("timeout_valid", {31'd0, result_valid}, 32'd0);
        // A late done in IDLE must not disturb the sticky error.
        m2_done = 1'b1;
        m3_done = 1'b1;
        step();
        m2_done = 1'b0;
        m3_done = 1'b0;
        step();
        chk("error_sticky", {31'd0, error}, 32'd1);
    endtask

    task automatic run_coincide();
        int c0;
        c0 = cyc;
        push(EV_M1, c0 + 1, 10'd0);
        push(EV_M2, c0 + C_TO + 2, 10'd0);
        push(EV_M3, c0 + C_TO + 4, 10'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (C_TO) step();
        m1_done = 1'b1;
        step();
        m1_done = 1'b0;
        chk("coincide_no_error", {31'd0, error}, 32'd0);
        step();
        m2_done = 1'b1;
        step();
        m2_done = 1'b0;
        step();
        m3_done  = 1'b1;
        m3_digit = 10'h001;
        abort    = 1'b1;
        step();
        m3_done  = 1'b0;
        m3_digit = 10'd0;
        abort    = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        chk("abort_valid", {31'd0, result_valid}, 32'd0);
        chk("abort_error", {31'd0, error}, 32'd0);
        step();
    endtask

    task automatic run_spurious();
        int c0;
        c0 = cyc;
        dbg_req   = 1'b1;
        dbg_raddr = 4'h7;
        m3_raddr  = 4'h3;
        #1;
        chk("idle_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("idle_regf_raddr", {28'd0, regf_raddr}, 32'h7);
        push(EV_M1, c0 + 1, 10'd0);
        push(EV_M2, c0 + 5, 10'd0);
        push(EV_M3, c0 + 8, 10'd0);
        push(EV_DONE, c0 + 11, 10'h200);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        m3_done = 1'b1;
        step();
        m3_done = 1'b0;
        chk("spurious_busy", {31'd0, busy}, 32'd1);
        step();
        m1_done = 1'b1;
        step();
        m1_done = 1'b0;
        step();
        start = 1'b1;
        step();
        start   = 1'b0;
        m2_done = 1'b1;
        step();
        m2_done = 1'b0;
        step();
        chk("m3_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("m3_regf_raddr", {28'd0, regf_raddr}, 32'h3);
        step();
        m3_done  = 1'b1;
        m3_digit = 10'h200;
        step();
        m3_done  = 1'b0;
        m3_digit = 10'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        dbg_req = 1'b0;
        step();
    endtask

    task automatic run_async_reset();
        int c0;
        c0 = cyc;
        dbg_req   = 1'b1;
        dbg_raddr = 4'h7;
        m3_raddr  = 4'h5;
        push(EV_M1, c0 + 1, 10'd0);
        push(EV_M2, c0 + 3, 10'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        m1_done = 1'b1;
        step();
        m1_done = 1'b0;
        step();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        chk("pre_reset_gnt", {31'd0, dbg_gnt}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            {16'd0, busy, done, result_valid, error, err_stage, m1_start, m2_start, m3_start, result[6:0]},
            32'd0);
        chk("async_reset_result", {22'd0, result}, 32'd0);
        chk("async_reset_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("async_reset_raddr", {28'd0, regf_raddr}, 32'h5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        dbg_req = 1'b0;
        step();
        run_nominal(10'h004);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        m1_done   = 1'b0;
        m2_done   = 1'b0;
        m3_done   = 1'b0;
        m3_digit  = 10'd0;
        m3_raddr  = 4'h9;
        dbg_req   = 1'b1;
        dbg_raddr = 4'h2;
        #1;
        chk("reset_outputs",
            {16'd0, busy, done, result_valid, error, err_stage, m1_start, m2_start, m3_start, result[6:0]},
            32'd0);
        chk("reset_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("reset_raddr", {28'd0, regf_raddr}, 32'h9);
        #11;
        rst     = 1'b1;
        dbg_req = 1'b0;
        step();

        // Abort and done in IDLE are ignored.
        abort   = 1'b1;
        m1_done = 1'b1;
        step();
        abort   = 1'b0;
        m1_done = 1'b0;
        step();
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        run_nominal(10'b0000100000);
        run_nominal(10'h100);
        run_timeout(2);
        run_nominal(10'h002);
        run_timeout(3);
        run_coincide();
        run_spurious();
        run_async_reset();

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
